// File: rtl/cpu_pkg.sv
// ============================================================================
// Package : cpu_pkg
// Brief   : Shared fetch-state encoding, fault-cause codes and instruction size.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

  typedef logic [1:0] fault_cause_t;

  localparam fault_cause_t FC_NONE     = 2'b00;
  localparam fault_cause_t FC_MISALIGN = 2'b01;
  localparam fault_cause_t FC_RANGE    = 2'b10;
  localparam fault_cause_t FC_OVERRUN  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/fetch_addr_check.sv
// ============================================================================
// Module : fetch_addr_check
// Brief  : Combinational legality check of a fetch target address.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_addr_check
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              legal,
  output fault_cause_t      cause
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INSTR_BYTES);

  logic misalign;
  logic range_err;

  always_comb begin
    misalign  = |addr[1:0];
    range_err = addr > LAST_PC;
    legal     = !misalign && !range_err;
    // Misalignment is reported in preference to range when both apply.
    if (misalign)       cause = FC_MISALIGN;
    else if (range_err) cause = FC_RANGE;
    else                cause = FC_NONE;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
// Module : instr_fetch_ctrl
// Brief  : PC owner and fetch sequencer with decode handshake, redirects and
//          sticky fault reporting. FETCH_PERF_CNT_EN adds fetch/stall counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_BYTES = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fault,
  output logic [1:0]        fault_cause
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INSTR_BYTES);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  fault_cause_t      cause_q, cause_d;

  logic              tgt_legal;
  fault_cause_t      tgt_cause;

  fetch_addr_check #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .addr  (redirect_target),
    .legal (tgt_legal),
    .cause (tgt_cause)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    imem_addr   = pc_q;
    instr_valid = 1'b0;

    case (state_q)
      S_BOOT: begin
        // Memory output is stale this cycle, so nothing is presented.
        state_d = S_RUN;
        if (redirect_valid) begin
          if (tgt_legal) begin
            pc_d      = redirect_target;
            imem_addr = redirect_target;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = tgt_cause;
          end
        end
      end
      S_RUN: begin
        instr_valid = !redirect_valid;
        if (redirect_valid) begin
          if (tgt_legal) begin
            pc_d      = redirect_target;
            imem_addr = redirect_target;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = tgt_cause;
          end
        end else if (instr_ready) begin
          if (pc_q == LAST_PC) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = FC_OVERRUN;
          end else begin
            pc_d      = pc_q + STEP;
            imem_addr = pc_q + STEP;
          end
        end
      end
      S_FAULT: begin
      end
      default: state_d = S_BOOT;
    endcase

    if (rst) begin
      imem_addr   = RESET_PC;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign instr       = imem_instr;
  assign instr_pc    = pc_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // instr_valid is already low in S_FAULT, which freezes both counters there.
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (instr_valid && instr_ready && (fetched_q != 32'hFFFF_FFFF))
      fetched_d = fetched_q + 32'd1;
    if (instr_valid && !instr_ready && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
// Module : tb_instr_fetch_ctrl
// Brief  : Vector-table bench for instr_fetch_ctrl around a 256-byte
//          big-endian registered instruction memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;
  logic [1:0]  fault_cause;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .ADDR_W    (32),
    .MEM_BYTES (256),
    .RESET_PC  (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fault           (fault),
    .fault_cause     (fault_cause)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem[b], mem[8'(b + 8'd1)], mem[8'(b + 8'd2)], mem[8'(b + 8'd3)]};
  endfunction

  always @(posedge clk) imem_instr <= word_at(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ef;
    logic [1:0]  ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic ef, input logic [1:0] ec);
    vec_t v;
    v = '{rst: r, rdy: rdy, rv: rv, tgt: tgt, ev: ev, epc: epc, eaddr: eaddr, ef: ef, ec: ec};
    vecs.push_back(v);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);

    //  rst rdy rv tgt        valid pc       addr     flt cause
    add(0, 1, 0, 32'h0,      0, 32'h0,   32'h0,   0, 2'd0); // 0 boot bubble
    add(0, 1, 0, 32'h0,      1, 32'h0,   32'h4,   0, 2'd0); // 1
    add(0, 1, 0, 32'h0,      1, 32'h4,   32'h8,   0, 2'd0); // 2
    add(0, 0, 0, 32'h0,      1, 32'h8,   32'h8,   0, 2'd0); // 3 stall
    add(0, 0, 0, 32'h0,      1, 32'h8,   32'h8,   0, 2'd0); // 4
    add(0, 0, 0, 32'h0,      1, 32'h8,   32'h8,   0, 2'd0); // 5
    add(0, 1, 0, 32'h0,      1, 32'h8,   32'hC,   0, 2'd0); // 6 resume
    add(0, 1, 0, 32'h0,      1, 32'hC,   32'h10,  0, 2'd0); // 7
    add(0, 1, 1, 32'h40,     0, 32'h10,  32'h40,  0, 2'd0); // 8 legal redirect
    add(0, 1, 0, 32'h0,      1, 32'h40,  32'h44,  0, 2'd0); // 9
    add(0, 1, 1, 32'h42,     0, 32'h44,  32'h44,  0, 2'd0); // 10 misaligned
    add(0, 1, 1, 32'h10,     0, 32'h44,  32'h44,  1, 2'd1); // 11 ignored in fault
    add(0, 1, 0, 32'h0,      0, 32'h44,  32'h44,  1, 2'd1); // 12
    add(1, 1, 1, 32'h20,     0, 32'h0,   32'h0,   1, 2'd1); // 13 rst beats redirect
    add(0, 1, 0, 32'h0,      0, 32'h0,   32'h0,   0, 2'd0); // 14
    add(0, 1, 1, 32'h100,    0, 32'h0,   32'h0,   0, 2'd0); // 15 out of range
    add(0, 1, 0, 32'h0,      0, 32'h0,   32'h0,   1, 2'd2); // 16
    add(1, 1, 0, 32'h0,      0, 32'h0,   32'h0,   1, 2'd2); // 17
    add(0, 1, 1, 32'hFC,     0, 32'h0,   32'hFC,  0, 2'd0); // 18 redirect in boot
    add(0, 1, 0, 32'h0,      1, 32'hFC,  32'hFC,  0, 2'd0); // 19 overrun accept
    add(0, 1, 0, 32'h0,      0, 32'hFC,  32'hFC,  1, 2'd3); // 20
    add(1, 1, 1, 32'h40,     0, 32'h0,   32'h0,   1, 2'd3); // 21
    add(0, 0, 0, 32'h0,      0, 32'h0,   32'h0,   0, 2'd0); // 22
    add(0, 0, 0, 32'h0,      1, 32'h0,   32'h0,   0, 2'd0); // 23
    add(0, 0, 1, 32'h101,    0, 32'h0,   32'h0,   0, 2'd0); // 24 both errors
    add(0, 0, 0, 32'h0,      0, 32'h0,   32'h0,   1, 2'd1); // 25 misalign wins

    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst             = vecs[i].rst;
      instr_ready     = vecs[i].rdy;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].eaddr);
      check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].ef));
      check($sformatf("v%0d_cause", i), 32'(fault_cause), 32'(vecs[i].ec));
      if (!vecs[i].rst) check($sformatf("v%0d_pc", i), instr_pc, vecs[i].epc);
      if (vecs[i].ev) check($sformatf("v%0d_instr", i), instr, word_at(vecs[i].epc));
`ifdef FETCH_PERF_CNT_EN
      if (i == 7) begin
        check("perf_fetched", perf_fetched, 32'd3);
        check("perf_stall", perf_stall, 32'd3);
      end
`endif
      @(posedge clk); #1;
    end

    // Fresh reset then bounded wait for the first valid fetch.
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    waited = 0;
    while (!instr_valid && waited < 4) begin
      @(posedge clk); #1;
      waited++;
    end
    @(negedge clk);
    check("seq_first_valid", 32'(instr_valid), 32'd1);
    check("seq_bubble_cycles", 32'(waited), 32'd1);
    check("seq_pc0", instr_pc, 32'h0);
    check("seq_instr0", instr, word_at(32'h0));
    @(posedge clk); #1;
    @(negedge clk);
    check("seq_pc4", instr_pc, 32'h4);
    check("seq_instr4", instr, word_at(32'h4));
    check("seq_addr8", imem_addr, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    check("seq_perf_fetched", perf_fetched, 32'd1);
    check("seq_perf_stall", perf_stall, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
